// File: rtl/apb_bridge_pkg.sv
// Shared types for the AHB-to-APB bridge controller: FSM state encoding and
// the request record carried from the AHB slave stage to the APB master side.
// Request field widths cap the controller's ADDR_W / DATA_W at 32 bits.
package apb_bridge_pkg;

  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
    logic                  write;
  } apb_req_t;

endpackage

// File: rtl/apb_req_buffer.sv
// One-entry holding register for a request accepted while a transfer is
// already in progress. push and pop never coincide because upstream is
// stalled whenever the entry is occupied.
module apb_req_buffer
  import apb_bridge_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  apb_req_t push_data,
  output logic     full,
  output apb_req_t data
);

  logic     full_q;
  apb_req_t data_q;

  // occupancy flag and stored request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      if (push) begin
        data_q <= push_data;
        full_q <= 1'b1;
      end else if (pop) begin
        full_q <= 1'b0;
      end
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/apb_controller.sv
// APB master side of the AHB-to-APB bridge.
//
//   state  | meaning
//   IDLE   | no transfer; PSEL=0, PENABLE=0
//   SETUP  | first APB phase, one cycle; PSEL=1, PENABLE=0
//   ACCESS | second APB phase, held until PREADY; PSEL=1, PENABLE=1
//
// Optional feature macro: APB_TIMEOUT_EN. When defined, an ACCESS phase that
// lasts TIMEOUT cycles without PREADY is abandoned and ERR pulses; when not
// defined, ACCESS waits for PREADY indefinitely and ERR is tied low.
module apb_controller
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              VALID,
  input  logic [ADDR_W-1:0] HADDR_TEMP,
  input  logic [DATA_W-1:0] HWDATA_TEMP,
  input  logic              HWRITE_TEMP,
  output logic              HREADY_OUT,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA,
  output logic [DATA_W-1:0] HRDATA,
  output logic              RDATA_VALID,
  output logic              ERR
);

  apb_state_e        state_q, state_d;
  apb_req_t          in_req, buf_data, next_req, cur_req_q;
  logic              buf_full;
  logic              accept;
  logic              push, pop, load, sel_pending;
  logic              complete, done;
  logic              rd_complete;
  logic [DATA_W-1:0] hrdata_q;
  logic              rdata_valid_q;

  assign in_req.addr  = REQ_ADDR_W'(HADDR_TEMP);
  assign in_req.wdata = REQ_DATA_W'(HWDATA_TEMP);
  assign in_req.write = HWRITE_TEMP;

  // Upstream stall comes straight off the buffer's full flop, so there is
  // no combinational path from any input to HREADY_OUT.
  assign HREADY_OUT = ~buf_full;
  assign accept     = VALID & HREADY_OUT;

  assign complete    = (state_q == ACCESS) & PREADY;
  assign rd_complete = complete & ~cur_req_q.write;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             timeout;
  logic             err_q;

  // Down-counter loaded on the SETUP cycle; reaching zero in ACCESS without
  // PREADY means TIMEOUT ACCESS cycles have elapsed.
  assign timeout = (state_q == ACCESS) & ~PREADY & (cnt_q == '0);
  assign done    = complete | timeout;

  // ACCESS cycle budget
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q <= '0;
    end else if (state_q == SETUP) begin
      cnt_q <= CNT_W'(TIMEOUT - 1);
    end else if ((state_q == ACCESS) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // one-cycle error pulse following an abandoned transfer
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout;
    end
  end

  assign ERR = err_q;
`else
  assign done = complete;
  assign ERR  = 1'b0;
`endif

  // state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state, buffer control and SETUP load selection
  always_comb begin
    state_d     = state_q;
    push        = 1'b0;
    pop         = 1'b0;
    load        = 1'b0;
    sel_pending = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          load    = 1'b1;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        push    = accept;
      end
      ACCESS: begin
        if (done) begin
          // A full buffer stalls upstream, so accept is low whenever the
          // pending entry is taken here.
          if (buf_full) begin
            state_d     = SETUP;
            pop         = 1'b1;
            load        = 1'b1;
            sel_pending = 1'b1;
          end else if (accept) begin
            state_d = SETUP;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          push = accept;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign next_req = sel_pending ? buf_data : in_req;

  // transfer address/data/direction, held stable from SETUP to completion
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cur_req_q <= '0;
    end else if (load) begin
      cur_req_q <= next_req;
    end
  end

  // read data capture and its one-cycle valid pulse
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hrdata_q      <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      rdata_valid_q <= rd_complete;
      if (rd_complete) begin
        hrdata_q <= PRDATA;
      end
    end
  end

  apb_req_buffer u_req_buffer (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .push      (push),
    .pop       (pop),
    .push_data (in_req),
    .full      (buf_full),
    .data      (buf_data)
  );

  assign PSEL        = (state_q != IDLE);
  assign PENABLE     = (state_q == ACCESS);
  assign PWRITE      = cur_req_q.write;
  assign PADDR       = ADDR_W'(cur_req_q.addr);
  assign PWDATA      = DATA_W'(cur_req_q.wdata);
  assign HRDATA      = hrdata_q;
  assign RDATA_VALID = rdata_valid_q;

endmodule

// File: tb/tb_apb_controller.sv
// Directed bench for apb_controller: reset values, single write, stalled
// read, back-to-back with pending buffer, acceptance at completion,
// ACCESS timeout (or indefinite wait without APB_TIMEOUT_EN), and reset
// asserted mid-transfer with a pending entry.
module tb_apb_controller;

  logic        HCLK;
  logic        HRESETn;
  logic        VALID;
  logic [31:0] HADDR_TEMP;
  logic [31:0] HWDATA_TEMP;
  logic        HWRITE_TEMP;
  logic        HREADY_OUT;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic [31:0] HRDATA;
  logic        RDATA_VALID;
  logic        ERR;

  int total = 0;
  int bad   = 0;

  apb_controller #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (16)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .VALID       (VALID),
    .HADDR_TEMP  (HADDR_TEMP),
    .HWDATA_TEMP (HWDATA_TEMP),
    .HWRITE_TEMP (HWRITE_TEMP),
    .HREADY_OUT  (HREADY_OUT),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PREADY      (PREADY),
    .PRDATA      (PRDATA),
    .HRDATA      (HRDATA),
    .RDATA_VALID (RDATA_VALID),
    .ERR         (ERR)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic w);
    VALID       = 1'b1;
    HADDR_TEMP  = a;
    HWDATA_TEMP = d;
    HWRITE_TEMP = w;
  endtask

  initial begin
    HRESETn     = 1'b0;
    VALID       = 1'b0;
    HADDR_TEMP  = '0;
    HWDATA_TEMP = '0;
    HWRITE_TEMP = 1'b0;
    PREADY      = 1'b0;
    PRDATA      = '0;

    // reset values
    #12;
    check("rst_psel",    PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite",  PWRITE, 0);
    check("rst_paddr",   PADDR, 0);
    check("rst_pwdata",  PWDATA, 0);
    check("rst_hrdata",  HRDATA, 0);
    check("rst_rvalid",  RDATA_VALID, 0);
    check("rst_err",     ERR, 0);
    check("rst_hready",  HREADY_OUT, 1);
    HRESETn = 1'b1;
    tick();

    // single write, PREADY high immediately
    req(32'h10, 32'hA5A5, 1'b1);
    PREADY = 1'b1;
    tick();
    VALID = 1'b0;
    check("w1_setup_psel",    PSEL, 1);
    check("w1_setup_penable", PENABLE, 0);
    check("w1_paddr",         PADDR, 32'h10);
    check("w1_pwdata",        PWDATA, 32'hA5A5);
    check("w1_pwrite",        PWRITE, 1);
    tick();
    check("w1_access_penable", PENABLE, 1);
    tick();
    check("w1_idle_psel",  PSEL, 0);
    check("w1_hrdata",     HRDATA, 0);
    check("w1_rvalid",     RDATA_VALID, 0);
    check("w1_hold_paddr", PADDR, 32'h10);

    // read, PREADY low for three ACCESS cycles
    PREADY = 1'b0;
    req(32'h20, 32'h0, 1'b0);
    tick();
    VALID = 1'b0;
    tick();
    check("r1_access", PENABLE, 1);
    tick();
    tick();
    tick();
    check("r1_held_access", PENABLE, 1);
    check("r1_no_rvalid",   RDATA_VALID, 0);
    PREADY = 1'b1;
    PRDATA = 32'h1234;
    tick();
    check("r1_hrdata",     HRDATA, 32'h1234);
    check("r1_rvalid_on",  RDATA_VALID, 1);
    check("r1_idle",       PSEL, 0);
    PRDATA = 32'h9999;
    tick();
    check("r1_rvalid_off", RDATA_VALID, 0);
    check("r1_hrdata_hold", HRDATA, 32'h1234);

    // three back-to-back writes, first ACCESS stalled two cycles
    PREADY = 1'b0;
    req(32'h100, 32'h1, 1'b1);
    tick();
    check("b2b_setup1", PADDR, 32'h100);
    req(32'h104, 32'h2, 1'b1);
    tick();
    check("b2b_hready_drop", HREADY_OUT, 0);
    req(32'h108, 32'h3, 1'b1);
    tick();
    tick();
    check("b2b_still_paddr1", PADDR, 32'h100);
    PREADY = 1'b1;
    tick();
    check("b2b_setup2_paddr", PADDR, 32'h104);
    check("b2b_setup2_psel",  PSEL, 1);
    check("b2b_setup2_pen",   PENABLE, 0);
    check("b2b_hready_back",  HREADY_OUT, 1);
    tick();
    VALID = 1'b0;
    check("b2b_access2_paddr", PADDR, 32'h104);
    check("b2b_hready_full2",  HREADY_OUT, 0);
    tick();
    check("b2b_setup3_paddr", PADDR, 32'h108);
    check("b2b_setup3_pwdata", PWDATA, 32'h3);
    check("b2b_setup3_psel",  PSEL, 1);
    check("b2b_hready_back2", HREADY_OUT, 1);
    tick();
    check("b2b_access3", PENABLE, 1);
    tick();
    check("b2b_idle", PSEL, 0);

    // request accepted on the completion edge with an empty buffer
    req(32'h400, 32'h0, 1'b0);
    PRDATA = 32'hBEEF;
    tick();
    VALID = 1'b0;
    tick();
    req(32'h404, 32'h77, 1'b1);
    tick();
    VALID = 1'b0;
    check("acc_hrdata",   HRDATA, 32'hBEEF);
    check("acc_rvalid",   RDATA_VALID, 1);
    check("acc_paddr",    PADDR, 32'h404);
    check("acc_pwrite",   PWRITE, 1);
    check("acc_setup_pen", PENABLE, 0);
    check("acc_psel",     PSEL, 1);
    tick();
    tick();
    check("acc_idle",      PSEL, 0);
    check("acc_hrdata_wr", HRDATA, 32'hBEEF);

    // stalled read: timeout when enabled, indefinite wait otherwise
    PREADY = 1'b0;
    PRDATA = 32'hDEAD;
    req(32'h300, 32'h0, 1'b0);
    tick();
    VALID = 1'b0;
    tick();
`ifdef APB_TIMEOUT_EN
    repeat (15) tick();
    check("to_before_psel", PSEL, 1);
    check("to_before_err",  ERR, 0);
    tick();
    check("to_err",    ERR, 1);
    check("to_psel",   PSEL, 0);
    check("to_hrdata", HRDATA, 32'hBEEF);
    check("to_rvalid", RDATA_VALID, 0);
    tick();
    check("to_err_off", ERR, 0);
`else
    repeat (20) tick();
    check("nto_psel",    PSEL, 1);
    check("nto_penable", PENABLE, 1);
    check("nto_err",     ERR, 0);
    PREADY = 1'b1;
    tick();
    check("nto_hrdata", HRDATA, 32'hDEAD);
    check("nto_rvalid", RDATA_VALID, 1);
    check("nto_idle",   PSEL, 0);
`endif

    // reset mid-ACCESS with a pending entry
    PREADY = 1'b0;
    req(32'h500, 32'h0, 1'b0);
    tick();
    req(32'h504, 32'h55, 1'b1);
    tick();
    VALID = 1'b0;
    check("mr_pending_full", HREADY_OUT, 0);
    tick();
    check("mr_in_access", PENABLE, 1);
    HRESETn = 1'b0;
    #1;
    check("mr_psel",    PSEL, 0);
    check("mr_penable", PENABLE, 0);
    check("mr_hready",  HREADY_OUT, 1);
    check("mr_paddr",   PADDR, 0);
    check("mr_hrdata",  HRDATA, 0);
    #2;
    HRESETn = 1'b1;
    PREADY  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mr_no_stale_psel", PSEL, 0);
      check("mr_no_stale_paddr", PADDR, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
